// File: rtl/mem_access.sv
// mem_access: data-memory access stage. Issues byte/half/word loads and
// stores on a req/ack bus, extends load data, stalls the pipeline while a
// transaction is outstanding and aborts requests that never get an ack.
//
//  state | meaning
//  IDLE  | no bus transaction; accept the MEM-stage instruction
//  BUSY  | request outstanding; waiting for dmem_ack or watchdog expiry
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_valid,
    input  logic [31:0] MEM_alu_out,
    input  logic [31:0] MEM_wdata,
    input  logic        MEM_read,
    input  logic        MEM_write,
    input  logic [1:0]  MEM_size,
    input  logic        MEM_unsigned,
    output logic        MEM_stall,
    output logic [31:0] MEM_rdata,
    output logic        MEM_done,
    output logic        MEM_misaligned,
    output logic        MEM_bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] wd_cnt;
    logic [1:0]    lat_off;
    logic [1:0]    lat_size;
    logic          lat_uns;
    logic          lat_read;

    logic          aligned;
    logic          access;
    logic          start;
    logic          timeout;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_val;

    // Alignment check, start condition, watchdog expiry and stall request.
    always_comb begin
        case (MEM_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~MEM_alu_out[0];
            default: aligned = (MEM_alu_out[1:0] == 2'b00);
        endcase
        access  = MEM_valid & (MEM_read | MEM_write);
        start   = access & aligned;
        // Abort on the cycle the countdown would hit zero, so dmem_req stays
        // high for exactly TIMEOUT_CYCLES cycles without an ack.
        timeout = (TIMEOUT_CYCLES != 0) && (state == BUSY) && !dmem_ack &&
                  (wd_cnt == CW'(1));
        MEM_stall = rst_n & (((state == IDLE) & start) |
                             ((state == BUSY) & ~dmem_ack & ~timeout));
    end

    // Store lane placement: replicate data across lanes, enable the target bytes.
    always_comb begin
        case (MEM_size)
            2'b00: begin
                st_be    = 4'b0001 << MEM_alu_out[1:0];
                st_wdata = {4{MEM_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = MEM_alu_out[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{MEM_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = MEM_wdata;
            end
        endcase
    end

    // Load lane select and sign/zero extension from the latched access info.
    always_comb begin
        ld_byte = dmem_rdata[{lat_off, 3'b000} +: 8];
        ld_half = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_size)
            2'b00:   load_val = {{24{~lat_uns & ld_byte[7]}}, ld_byte};
            2'b01:   load_val = {{16{~lat_uns & ld_half[15]}}, ld_half};
            default: load_val = dmem_rdata;
        endcase
    end

    // Access FSM with registered bus outputs, result and status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            wd_cnt         <= '0;
            lat_off        <= 2'b00;
            lat_size       <= 2'b00;
            lat_uns        <= 1'b0;
            lat_read       <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'h0;
            dmem_be        <= 4'h0;
            dmem_wdata     <= 32'h0;
            MEM_rdata      <= 32'h0;
            MEM_done       <= 1'b0;
            MEM_misaligned <= 1'b0;
            MEM_bus_err    <= 1'b0;
        end else begin
            MEM_done       <= 1'b0;
            MEM_misaligned <= 1'b0;
            MEM_bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= BUSY;
                        lat_off    <= MEM_alu_out[1:0];
                        lat_size   <= MEM_size;
                        lat_uns    <= MEM_unsigned;
                        lat_read   <= MEM_read;
                        wd_cnt     <= CW'(TIMEOUT_CYCLES);
                        dmem_req   <= 1'b1;
                        dmem_we    <= MEM_write & ~MEM_read;
                        dmem_addr  <= {MEM_alu_out[31:2], 2'b00};
                        dmem_be    <= MEM_read ? 4'b1111 : st_be;
                        dmem_wdata <= MEM_read ? 32'h0 : st_wdata;
                    end else if (access) begin
                        MEM_misaligned <= 1'b1;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        MEM_done <= 1'b1;
                        if (lat_read) MEM_rdata <= load_val;
                    end else if (timeout) begin
                        state       <= IDLE;
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        wd_cnt      <= '0;
                        MEM_bus_err <= 1'b1;
                    end else if (wd_cnt != '0) begin
                        wd_cnt <= wd_cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access.md
# mem_access

Data-memory access stage of the pipelined MIPS core, directly downstream of the execute-stage ALU. It takes the ALU result (effective address) and store data from the EX/MEM pipeline register and performs byte, halfword or word loads and stores over a request/acknowledge data-memory bus. Load data is returned sign- or zero-extended. The pipeline is stalled while a bus transaction is outstanding.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles `dmem_req` may stay high without `dmem_ack` before the access is aborted; 0 disables the watchdog.

Ports:
- clk  in  1  rising-edge clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- MEM_valid  in  1  an instruction occupies the MEM stage
- MEM_alu_out  in  32  effective address, registered EX_alu_out
- MEM_wdata  in  32  store data (rt value)
- MEM_read  in  1  load instruction
- MEM_write  in  1  store instruction
- MEM_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word
- MEM_unsigned  in  1  zero-extend the load (LBU/LHU) instead of sign-extending it
- MEM_stall  out  1  hold the IF/ID/EX/MEM pipeline registers
- MEM_rdata  out  32  extended load result, to WB
- MEM_done  out  1  one-cycle pulse: access completed
- MEM_misaligned  out  1  one-cycle pulse: address exception, no bus access made
- MEM_bus_err  out  1  one-cycle pulse: watchdog abort
- dmem_req  out  1  bus request
- dmem_we  out  1  write strobe
- dmem_addr  out  32  word address {addr[31:2], 2'b00}
- dmem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  bus completion; `dmem_rdata` is valid in the same cycle
- dmem_rdata  in  32  read word

## Operation
- FSM states: IDLE and BUSY.
- start = MEM_valid & (MEM_read | MEM_write) & aligned.
  - aligned means: bytes always; halfwords need addr[0]=0; words need addr[1:0]=00.
- IDLE, on start: latch the address, size, unsigned flag and direction, drive the bus registers, load the watchdog counter, and go to BUSY.
- If MEM_read and MEM_write are both high, read wins and the write is ignored.
- IDLE, misaligned access: no request and no stall. MEM_misaligned=1 in the next cycle.
- IDLE, non-memory instruction (MEM_valid=1, read=write=0): pass through, no stall, no pulses.
- BUSY: hold dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata stable until dmem_ack.
- On ack: drop dmem_req and go to IDLE.
  - Load: capture and extend dmem_rdata into MEM_rdata.
  - MEM_done=1 in the next cycle, for both loads and stores.
- Store lanes:
  - byte: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}
  - word: be = 1111, wdata = MEM_wdata
- Reads drive be=1111. Load lane select uses addr[1:0] for bytes and addr[1] for halves.
- Load extension: sign-extend bit 7 or bit 15 unless MEM_unsigned=1, in which case zero-extend.
- MEM_rdata holds its value until the next load completes. Stores and aborts leave it unchanged.
- Watchdog: decrement while BUSY without ack. On reaching 0, drop the request, go to IDLE, and set MEM_bus_err=1 in the next cycle. MEM_done is not asserted.
- dmem_ack while IDLE is ignored.

## Timing
- MEM_stall = (IDLE & start) | (BUSY & ~dmem_ack & ~timeout). It is combinational and forced to 0 while rst_n=0.
- Cycle t: start seen in IDLE, MEM_stall=1.
- Cycle t+1: dmem_req=1.
- Earliest ack is at t+1, which gives MEM_stall=0 at t+1 and MEM_done/MEM_rdata at t+2.
- Stall cycles per access = 1 + bus wait states.
- The pipeline advances on the edge where ack is seen. The next instruction may start in IDLE at t+2, back-to-back with the MEM_done pulse.
- Reset (rst_n=0 at a clock edge, including mid-BUSY) sets:
  - state=IDLE
  - dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata = 0
  - MEM_rdata = 0
  - MEM_done, MEM_misaligned, MEM_bus_err = 0
  - watchdog counter = 0
- After reset, an outstanding ack is ignored.
- All pulses are exactly one cycle wide.

## Test plan
- LW at 0x100, memory word 0x8000_00F0, ack after 3 wait states -> dmem_addr=0x100, be=1111, MEM_stall high 4 cycles, MEM_done one cycle later, MEM_rdata=0x8000_00F0.
- LB/LBU at 0x103 with word 0x80FF_7F01 -> LB gives 0xFFFF_FF80, LBU gives 0x0000_0080; LH at 0x102 gives 0xFFFF_80FF.
- SB 0xAB at 0x201, then SH 0x1234 at 0x202 -> be=0010 with wdata=0xABAB_ABAB, then be=1100 with wdata=0x1234_1234; dmem_we=1; MEM_rdata unchanged.
- LW at 0x102 and LH at 0x101 -> no dmem_req, no stall, MEM_misaligned pulse, no MEM_done.
- Ack never arrives, TIMEOUT_CYCLES=4 -> request aborted, MEM_bus_err pulse, stall released, FSM in IDLE.
- rst_n low for one cycle mid-BUSY, then a late ack -> all outputs 0, ack ignored; a following LW completes normally.
